// File: rtl/uart_alu_host_if.sv
// uart_alu_host_if: request, result and serial-line bundle of uart_alu_host
interface uart_alu_host_if #(
  parameter int N_BITS = 8,
  parameter int OP_BITS = 6
);
  logic req_valid, req_ready, tx, rx, res_valid, err, busy;
  logic [N_BITS-1:0] data_a, data_b, res_data;
  logic [OP_BITS-1:0] op;
  modport master (output req_valid, data_a, data_b, op, rx, input req_ready, tx, res_valid, res_data, err, busy);
  modport slave (input req_valid, data_a, data_b, op, rx, output req_ready, tx, res_valid, res_data, err, busy);
endinterface

// File: rtl/uart_alu_host.sv
// uart_alu_host: sends A, B, op as 8N1 frames and receives one result frame; UART_HOST_TIMEOUT_EN adds a response timeout
module uart_alu_host #(
  parameter int N_BITS = 8,
  parameter int OP_BITS = 6,
  parameter int F_CLOCK = 50_000_000,
  parameter int BAUDRATE = 9600,
  parameter int SAMPLING = 16,
  parameter int TIMEOUT_BITS = 64
) (
  input logic clk,
  input logic rst_n,
  uart_alu_host_if.slave bus
);
  localparam int DIV = (F_CLOCK + BAUDRATE * SAMPLING / 2) / (BAUDRATE * SAMPLING);
  localparam int DW = $clog2(DIV + 1);
  localparam int SW = $clog2(SAMPLING);
  localparam int BW = $clog2(N_BITS + 2);
  localparam logic [2:0] IDLE = 3'd0, SEND_A = 3'd1, SEND_B = 3'd2, SEND_OP = 3'd3, WAIT_RES = 3'd4;
  logic [2:0] state;
  logic [DW-1:0] div_cnt;
  logic [SW-1:0] tx_tick, rx_tick;
  logic [BW-1:0] tx_bit, rx_bit;
  logic [N_BITS-1:0] a_q, b_q, op_q, cur, rx_sh;
  logic [N_BITS+1:0] frame;
  logic tick, accept, sending, timeout;
  logic rx_s1, rx_s2, rx_q, rx_act, rx_start, rx_done, rx_stop;
  assign tick = div_cnt == DW'(DIV - 1);
  assign accept = bus.req_valid & bus.req_ready;
  assign sending = state == SEND_A || state == SEND_B || state == SEND_OP;
  assign cur = state == SEND_A ? a_q : state == SEND_B ? b_q : op_q;
  assign frame = {1'b1, cur, 1'b0};
  assign bus.req_ready = state == IDLE && !bus.res_valid && !bus.err;
  assign bus.busy = ~bus.req_ready;
  assign rx_start = ~rx_act & rx_q & ~rx_s2;
  // Divider restarts on acceptance so the first TX bit is exactly one bit-time long
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) div_cnt <= '0;
    else div_cnt <= (accept || tick) ? '0 : div_cnt + 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      bus.tx <= 1'b1;
      tx_tick <= '0;
      tx_bit <= '0;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      bus.res_valid <= 1'b0;
      bus.res_data <= '0;
      bus.err <= 1'b0;
    end else begin
      bus.res_valid <= 1'b0;
      bus.err <= 1'b0;
      if (accept) begin
        state <= SEND_A;
        a_q <= bus.data_a;
        b_q <= bus.data_b;
        op_q <= N_BITS'(bus.op);
        bus.tx <= 1'b0;
        tx_tick <= '0;
        tx_bit <= '0;
      end else if (sending && tick) begin
        tx_tick <= tx_tick == SW'(SAMPLING - 1) ? '0 : tx_tick + 1'b1;
        if (tx_tick == SW'(SAMPLING - 1)) begin
          tx_bit <= tx_bit == BW'(N_BITS + 1) ? '0 : tx_bit + 1'b1;
          bus.tx <= tx_bit == BW'(N_BITS + 1) ? state == SEND_OP : frame[tx_bit + 1'b1];
          if (tx_bit == BW'(N_BITS + 1)) state <= state == SEND_OP ? WAIT_RES : state + 3'd1;
        end
      end else if (state == WAIT_RES && (rx_done || timeout)) begin
        state <= IDLE;
        bus.res_valid <= rx_done & rx_stop;
        bus.err <= ~(rx_done & rx_stop);
        if (rx_done && rx_stop) bus.res_data <= rx_sh;
      end
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {rx_s1, rx_s2, rx_q} <= 3'b111;
    else {rx_s1, rx_s2, rx_q} <= {bus.rx, rx_s1, rx_s2};
  // Samples land mid-bit: tick SAMPLING/2-1 after the start edge, then every SAMPLING ticks
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rx_act <= 1'b0;
      rx_tick <= '0;
      rx_bit <= '0;
      rx_sh <= '0;
      rx_stop <= 1'b0;
      rx_done <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      if (rx_start) begin
        rx_act <= 1'b1;
        rx_tick <= '0;
        rx_bit <= '0;
      end else if (rx_act && tick) begin
        rx_tick <= rx_tick == SW'(SAMPLING - 1) ? '0 : rx_tick + 1'b1;
        if (rx_tick == SW'(SAMPLING / 2 - 1)) begin
          rx_bit <= rx_bit + 1'b1;
          if (rx_bit == '0) rx_act <= ~rx_s2;
          else if (rx_bit == BW'(N_BITS + 1)) begin
            rx_act <= 1'b0;
            rx_done <= 1'b1;
            rx_stop <= rx_s2;
          end else rx_sh <= {rx_s2, rx_sh[N_BITS-1:1]};
        end
      end
    end
`ifdef UART_HOST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_BITS * SAMPLING + 1);
  logic [TW-1:0] to_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) to_cnt <= '0;
    else to_cnt <= (state != WAIT_RES || rx_start) ? '0 : to_cnt + TW'(tick);
  assign timeout = tick && to_cnt == TW'(TIMEOUT_BITS * SAMPLING - 1);
`else
  assign timeout = 1'b0;
`endif
endmodule

// File: tb/tb_uart_alu_host.sv
// tb_uart_alu_host: random request/response traffic against a queue-based scoreboard
module tb_uart_alu_host;
  localparam int N = 8, OPB = 6, F_CLOCK = 640_000, BAUD = 10_000, SMP = 16, TOB = 64;
  localparam int BIT = 64;
  typedef struct {bit is_err; logic [7:0] data;} res_t;
  logic clk = 0, rst_n = 0;
  int checks = 0, fails = 0, frames_seen = 0, base_frames = 0, gen = 0;
  bit chk_ready = 0;
  logic [7:0] last_res = 8'h00;
  logic [7:0] exp_tx[$];
  res_t exp_res[$];
  always #5 clk = ~clk;
  uart_alu_host_if #(.N_BITS(N), .OP_BITS(OPB)) bus ();
  uart_alu_host #(.N_BITS(N), .OP_BITS(OPB), .F_CLOCK(F_CLOCK), .BAUDRATE(BAUD), .SAMPLING(SMP),
    .TIMEOUT_BITS(TOB)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Line decoder on tx: each frame is compared with the bytes the request should produce
  initial forever begin
    int g;
    logic [7:0] d;
    logic s0, s1;
    @(negedge clk);
    if (rst_n && !bus.tx) begin
      g = gen;
      repeat (BIT / 2) @(negedge clk);
      s0 = bus.tx;
      for (int i = 0; i < 8; i++) begin
        repeat (BIT) @(negedge clk);
        d[i] = bus.tx;
      end
      repeat (BIT) @(negedge clk);
      s1 = bus.tx;
      if (g == gen) begin
        check("tx_start_bit", s0, 0);
        check("tx_stop_bit", s1, 1);
        check("tx_frame_expected", exp_tx.size() > 0, 1);
        if (exp_tx.size() > 0) check("tx_frame_data", d, exp_tx.pop_front());
        frames_seen++;
      end
    end
  end

  initial forever begin
    res_t r;
    @(negedge clk);
    if (chk_ready) begin
      check("ready_after_result", bus.req_ready, 1);
      chk_ready = 0;
    end
    if (bus.res_valid || bus.err) begin
      check("valid_err_exclusive", bus.res_valid & bus.err, 0);
      check("result_expected", exp_res.size() > 0, 1);
      if (exp_res.size() > 0) begin
        r = exp_res.pop_front();
        check("result_is_err", bus.err, r.is_err);
        check("result_data", bus.res_data, r.data);
        chk_ready = 1;
      end
    end
  end

  task automatic wait_ready(input int budget, input string name, output int waited);
    waited = 0;
    while (!bus.req_ready && waited < budget) begin
      @(negedge clk);
      waited++;
    end
    check(name, bus.req_ready, 1);
  endtask

  task automatic request(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    int w;
    wait_ready(20 * BIT, "ready_before_request", w);
    @(posedge clk);
    #1;
    bus.req_valid = 1;
    bus.data_a = a;
    bus.data_b = b;
    bus.op = op;
    exp_tx.push_back(a);
    exp_tx.push_back(b);
    exp_tx.push_back({2'b00, op});
    base_frames = frames_seen;
    @(posedge clk);
    #1;
    bus.req_valid = 0;
    check("ready_low_after_accept", bus.req_ready, 0);
    check("busy_after_accept", bus.busy, 1);
  endtask

  task automatic wait_frames(input int n);
    int w = 0;
    while (frames_seen < base_frames + n && w < 40 * BIT) begin
      @(negedge clk);
      w++;
    end
    check("tx_frames_done", frames_seen - base_frames, n);
    check("ready_low_during_tx", bus.req_ready, 0);
  endtask

  task automatic send_rx(input logic [7:0] d, input bit stop);
    @(posedge clk);
    #1 bus.rx = 0;
    repeat (BIT) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 bus.rx = d[i];
      repeat (BIT) @(posedge clk);
    end
    #1 bus.rx = stop;
    repeat (BIT) @(posedge clk);
    #1 bus.rx = 1;
  endtask

  task automatic respond(input logic [7:0] r, input bit stop_ok);
    res_t e;
    int w;
    e.is_err = !stop_ok;
    e.data = stop_ok ? r : last_res;
    exp_res.push_back(e);
    if (stop_ok) last_res = r;
    send_rx(r, stop_ok);
    wait_ready(4 * BIT, "ready_after_response", w);
  endtask

  task automatic transact(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op,
                          input bit stop_ok, input bit glitch);
    logic [7:0] r;
    request(a, b, op);
    wait_frames(3);
    repeat (40) @(posedge clk);
    if (glitch) begin
      #1 bus.rx = 0;
      repeat (10) @(posedge clk);
      #1 bus.rx = 1;
      repeat (100) @(posedge clk);
    end
    r = (op == 6'h20) ? a + b : a - b;
    respond(r, stop_ok);
  endtask

  initial begin
    #(200_000 * 10);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    bus.req_valid = 0;
    bus.data_a = 0;
    bus.data_b = 0;
    bus.op = 0;
    bus.rx = 1;
    #40 rst_n = 1;
    repeat (2) @(negedge clk);
    check("reset_tx", bus.tx, 1);
    check("reset_ready", bus.req_ready, 1);
    check("reset_valid", bus.res_valid, 0);
    check("reset_data", bus.res_data, 0);
    check("reset_err", bus.err, 0);
    check("reset_busy", bus.busy, 0);
    transact(8'h01, 8'h02, 6'h20, 1, 0);
    transact(8'h01, 8'h02, 6'h20, 0, 0);
    send_rx(8'h55, 1);
    repeat (50) @(negedge clk);
    check("idle_frame_ignored", bus.res_data, last_res);
    check("idle_frame_ready", bus.req_ready, 1);
    transact(8'hF0, 8'h1F, 6'h20, 1, 1);
    for (int i = 0; i < 6; i++)
      transact(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
               $urandom_range(0, 1) ? 6'h20 : 6'($urandom_range(0, 63)), $urandom_range(0, 3) != 0, 0);
    request(8'hAA, 8'hBB, 6'h20);
    wait_frames(1);
    repeat (100) @(posedge clk);
    #2;
    gen++;
    exp_tx.delete();
    rst_n = 0;
    last_res = 8'h00;
    #1;
    check("async_reset_tx", bus.tx, 1);
    check("async_reset_busy", bus.busy, 0);
    #20 rst_n = 1;
    repeat (800) @(negedge clk);
    check("post_reset_data", bus.res_data, 0);
    transact(8'h05, 8'h07, 6'h20, 1, 0);
    request(8'h11, 8'h22, 6'h20);
    wait_frames(3);
`ifdef UART_HOST_TIMEOUT_EN
    begin
      res_t e;
      e.is_err = 1;
      e.data = last_res;
      exp_res.push_back(e);
      wait_ready(TOB * BIT + 200, "timeout_exit", w);
      check("timeout_latency", (w >= TOB * BIT) && (w <= TOB * BIT + 100), 1);
    end
`else
    repeat (TOB * BIT + 10 * BIT) @(negedge clk);
    check("no_timeout_busy", bus.busy, 1);
    respond(8'h33, 1);
`endif
    repeat (20) @(negedge clk);
    check("exp_res_drained", exp_res.size(), 0);
    check("exp_tx_drained", exp_tx.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
